// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage.
//   state_t          : access FSM states (IDLE, WAIT)
//   MEM_BASE_DEF     : default byte address of word 0
//   DEPTH_WORDS_DEF  : default number of 32-bit words
//   REG_ADDR_W       : register-file index width
//   DATA_W           : datapath width
package mem_stage_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam int MEM_BASE_DEF    = 1024;
    localparam int DEPTH_WORDS_DEF = 64;
    localparam int REG_ADDR_W      = 5;
    localparam int DATA_W          = 32;

endpackage

// File: rtl/data_memory.sv
// Word-addressed data array with one synchronous write port and one
// synchronous read port.
//   clk, rst : clock; async active-high reset (clears the read register only)
//   wr_en    : write wr_data into array[addr] on the rising edge
//   rd_en    : register array[addr] into rd_data on the rising edge
//   addr     : word index
//   wr_data  : write data
//   rd_data  : registered read data (holds when rd_en = 0)
// The array itself is never reset. A same-edge read returns the pre-write word.
module data_memory
    import mem_stage_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] array [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) array[addr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        rd_data <= '0;
        else if (rd_en) rd_data <= array[addr];
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage with MEM/WB pipeline register and a multi-cycle data memory.
// Each load/store holds `ready` low for LATENCY cycles and retires on the
// following edge; non-memory ops pass straight through with no stall.
// Ports:
//   clk, rst                  : clock, async active-high reset
//   WB_EN_in, MEM_R_EN_in,
//   MEM_W_EN_in               : control bits from EXE/MEM
//   ALU_result_in             : byte address / ALU result
//   val_src2_in               : store data
//   dest_in                   : destination register
//   ready                     : 0 = freeze upstream stages
//   WB_EN_out, MEM_R_EN_out,
//   ALU_result_out, dest_out  : MEM/WB register
//   mem_read_value            : registered load data
//   mem_err                   : sticky out-of-range flag (MEM_BOUNDS_CHECK_EN only)
// Optional feature macro: MEM_BOUNDS_CHECK_EN. Without it the word index
// wraps modulo DEPTH_WORDS.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int MEM_BASE    = MEM_BASE_DEF,
    parameter int LATENCY     = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  WB_EN_in,
    input  logic                  MEM_R_EN_in,
    input  logic                  MEM_W_EN_in,
    input  logic [DATA_W-1:0]     ALU_result_in,
    input  logic [DATA_W-1:0]     val_src2_in,
    input  logic [REG_ADDR_W-1:0] dest_in,
    output logic                  ready,
    output logic                  WB_EN_out,
    output logic                  MEM_R_EN_out,
    output logic [DATA_W-1:0]     ALU_result_out,
    output logic [DATA_W-1:0]     mem_read_value,
    output logic [REG_ADDR_W-1:0] dest_out
`ifdef MEM_BOUNDS_CHECK_EN
    ,
    output logic                  mem_err
`endif
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    // Address decode: byte offset from base, word granularity.
    logic [DATA_W-1:0] word_full;
    logic [AW-1:0]     word_idx;
    logic              oob;

    assign word_full = (ALU_result_in - DATA_W'(MEM_BASE)) >> 2;
    assign word_idx  = AW'(word_full % DATA_W'(DEPTH_WORDS));

`ifdef MEM_BOUNDS_CHECK_EN
    // Below-base addresses wrap to huge offsets, but test them explicitly.
    assign oob = (ALU_result_in < DATA_W'(MEM_BASE)) ||
                 (word_full >= DATA_W'(DEPTH_WORDS));
`else
    assign oob = 1'b0;
`endif

    logic mem_op, is_store, is_load;
    assign mem_op   = MEM_R_EN_in | MEM_W_EN_in;
    assign is_store = MEM_W_EN_in;                 // store wins when both set
    assign is_load  = MEM_R_EN_in & ~MEM_W_EN_in;

    // Access FSM
    state_t     state, next_state;
    logic [3:0] cnt, next_cnt;
    logic       retire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        ready      = 1'b1;
        retire     = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    ready      = 1'b0;
                    next_state = WAIT;
                    next_cnt   = 4'(LATENCY - 1);
                end
            end
            WAIT: begin
                if (cnt != 4'd0) begin
                    ready    = 1'b0;
                    next_cnt = cnt - 4'd1;
                end else begin
                    retire     = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Array is only touched on the retire edge, so mid-access input
    // changes cannot corrupt it.
    logic              wr_en, rd_en;
    logic [DATA_W-1:0] rd_data;

    assign wr_en = retire & is_store & ~oob;
    assign rd_en = retire & is_load  & ~oob;

    data_memory #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_data_memory (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .rd_en   (rd_en),
        .addr    (word_idx),
        .wr_data (val_src2_in),
        .rd_data (rd_data)
    );

    // MEM/WB register: capture whenever ready, otherwise insert a bubble
    // (control bits cleared, data fields held).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            WB_EN_out      <= 1'b0;
            MEM_R_EN_out   <= 1'b0;
            ALU_result_out <= '0;
            dest_out       <= '0;
        end else if (ready) begin
            WB_EN_out      <= WB_EN_in;
            MEM_R_EN_out   <= MEM_R_EN_in;
            ALU_result_out <= ALU_result_in;
            dest_out       <= dest_in;
        end else begin
            WB_EN_out      <= 1'b0;
            MEM_R_EN_out   <= 1'b0;
        end
    end

`ifdef MEM_BOUNDS_CHECK_EN
    // An out-of-range load leaves rd_data untouched; rd_zero masks it to 0
    // until the next in-range load retires.
    logic rd_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_zero <= 1'b0;
            mem_err <= 1'b0;
        end else if (retire) begin
            if (is_load) rd_zero <= oob;
            if (oob)     mem_err <= 1'b1;
        end
    end

    assign mem_read_value = rd_zero ? '0 : rd_data;
`else
    assign mem_read_value = rd_data;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed table, reset-mid-access
// sequence, optional bounds-check sequence, randomized ops against a
// word-array reference model, and a LATENCY=1 back-to-back load sequence.
module tb_mem_stage;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        wb_in, mr_in, mw_in;
    logic [31:0] alu_in, v2_in;
    logic [4:0]  dest_in;

    logic        rdy3, wb3, mr3, rdy1, wb1, mr1;
    logic [31:0] alu3, rv3, alu1, rv1;
    logic [4:0]  d3, d1;
`ifdef MEM_BOUNDS_CHECK_EN
    logic        err3, err1;
`endif

    mem_stage #(.DEPTH_WORDS(64), .MEM_BASE(1024), .LATENCY(3)) dut3 (
        .clk(clk), .rst(rst),
        .WB_EN_in(wb_in), .MEM_R_EN_in(mr_in), .MEM_W_EN_in(mw_in),
        .ALU_result_in(alu_in), .val_src2_in(v2_in), .dest_in(dest_in),
        .ready(rdy3), .WB_EN_out(wb3), .MEM_R_EN_out(mr3),
        .ALU_result_out(alu3), .mem_read_value(rv3), .dest_out(d3)
`ifdef MEM_BOUNDS_CHECK_EN
        , .mem_err(err3)
`endif
    );

    mem_stage #(.DEPTH_WORDS(64), .MEM_BASE(1024), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .WB_EN_in(wb_in), .MEM_R_EN_in(mr_in), .MEM_W_EN_in(mw_in),
        .ALU_result_in(alu_in), .val_src2_in(v2_in), .dest_in(dest_in),
        .ready(rdy1), .WB_EN_out(wb1), .MEM_R_EN_out(mr1),
        .ALU_result_out(alu1), .mem_read_value(rv1), .dest_out(d1)
`ifdef MEM_BOUNDS_CHECK_EN
        , .mem_err(err1)
`endif
    );

    // Observed instance selection
    bit          use1 = 1'b0;
    logic        c_rdy, c_wb, c_mr;
    logic [31:0] c_alu, c_rv;
    logic [4:0]  c_d;
    assign c_rdy = use1 ? rdy1 : rdy3;
    assign c_wb  = use1 ? wb1  : wb3;
    assign c_mr  = use1 ? mr1  : mr3;
    assign c_alu = use1 ? alu1 : alu3;
    assign c_rv  = use1 ? rv1  : rv3;
    assign c_d   = use1 ? d1   : d3;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply one op (called right after a negedge) and follow it to retirement.
    task automatic run_op(input logic we, input logic re, input logic wb,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [4:0] dest, input logic [31:0] exp_rv,
                          input string tag);
        int lows = 0;
        int lat  = use1 ? 1 : 3;
        wb_in = wb; mr_in = re; mw_in = we;
        alu_in = addr; v2_in = data; dest_in = dest;
        #1;
        while (c_rdy !== 1'b1 && lows < 40) begin
            lows++;
            @(posedge clk); #1;
            chk({tag, " bubble"}, {30'd0, c_wb, c_mr}, 32'd0);
            @(negedge clk); #1;
        end
        chk({tag, " stall"}, lows, (we | re) ? lat : 0);
        @(posedge clk); #1;
        chk({tag, " wb_out"},   c_wb,  wb);
        chk({tag, " mr_out"},   c_mr,  re);
        chk({tag, " alu_out"},  c_alu, addr);
        chk({tag, " dest_out"}, c_d,   dest);
        chk({tag, " rd_val"},   c_rv,  exp_rv);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wb_in = 0; mr_in = 0; mw_in = 0; alu_in = 0; v2_in = 0; dest_in = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Reference model: plain word array indexed by spec's address rule.
    logic [31:0] mdl [64];
    logic [31:0] rv_m;

    function automatic int unsigned widx(input logic [31:0] a);
        logic [31:0] off;
        off = (a - 32'd1024) >> 2;
        return off % 64;
    endfunction

    typedef struct {
        logic        we, re, wb;
        logic [31:0] addr, data;
        logic [4:0]  dest;
        logic [31:0] exp_rv;
    } vec_t;

    vec_t tbl [9];

    initial begin
        tbl[0] = '{0, 0, 1, 32'h0000_0007, 32'h0,         5'd3,  32'h0};
        tbl[1] = '{1, 0, 0, 32'd1028,      32'hDEAD_BEEF, 5'd0,  32'h0};
        tbl[2] = '{0, 1, 1, 32'd1028,      32'h0,         5'd5,  32'hDEAD_BEEF};
        tbl[3] = '{1, 0, 0, 32'd1028,      32'h0000_1234, 5'd0,  32'hDEAD_BEEF};
        tbl[4] = '{0, 1, 1, 32'd1030,      32'h0,         5'd6,  32'h0000_1234};
        tbl[5] = '{1, 0, 0, 32'd1032,      32'hA5A5_A5A5, 5'd0,  32'h0000_1234};
        tbl[6] = '{0, 0, 0, 32'hFFFF_FFF0, 32'h0,         5'd31, 32'h0000_1234};
        tbl[7] = '{1, 1, 1, 32'd1036,      32'h0000_0099, 5'd9,  32'h0000_1234};
        tbl[8] = '{0, 1, 1, 32'd1036,      32'h0,         5'd10, 32'h0000_0099};

        // Reset state
        rst = 1'b1;
        wb_in = 0; mr_in = 0; mw_in = 0; alu_in = 0; v2_in = 0; dest_in = 0;
        #3;
        chk("rst ready3", rdy3, 1);
        chk("rst ready1", rdy1, 1);
        chk("rst outs3", {wb3, mr3, d3} | alu3 | rv3, 0);
        chk("rst outs1", {wb1, mr1, d1} | alu1 | rv1, 0);
`ifdef MEM_BOUNDS_CHECK_EN
        chk("rst mem_err", err3, 0);
`endif
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Directed table (LATENCY=3)
        for (int i = 0; i < 9; i++)
            run_op(tbl[i].we, tbl[i].re, tbl[i].wb, tbl[i].addr, tbl[i].data,
                   tbl[i].dest, tbl[i].exp_rv, $sformatf("vec%0d", i));

        // Reset on the 2nd stall cycle of a store: must not commit
        wb_in = 0; mr_in = 0; mw_in = 1; alu_in = 32'd1032; v2_in = 32'h55; dest_in = 0;
        @(posedge clk); #1;
        chk("midrst stalled", rdy3, 0);
        rst = 1'b1;
        mw_in = 0; alu_in = 0; v2_in = 0;
        #1;
        chk("midrst ready", rdy3, 1);
        chk("midrst outs", {wb3, mr3, d3} | alu3 | rv3, 0);
        @(negedge clk);
        rst = 1'b0;
        run_op(0, 1, 1, 32'd1032, 0, 5'd7, 32'hA5A5_A5A5, "midrst load");

`ifdef MEM_BOUNDS_CHECK_EN
        chk("err clear", err3, 0);
        run_op(1, 0, 0, 32'd1000, 32'h77, 5'd0, 32'hA5A5_A5A5, "oob store");
        chk("err after store", err3, 1);
        run_op(0, 1, 1, 32'd1024 + 32'd256, 0, 5'd2, 32'h0, "oob load");
        chk("err sticky", err3, 1);
        run_op(0, 1, 1, 32'd1032, 0, 5'd2, 32'hA5A5_A5A5, "post oob load");
        chk("err still", err3, 1);
        do_reset();
        chk("err reset", err3, 0);
`endif

        // Randomized ops against the model
        do_reset();
        rv_m = 0;
        for (int i = 0; i < 64; i++) begin
            mdl[i] = $urandom;
            run_op(1, 0, 0, 32'd1024 + 32'(4 * i), mdl[i], 5'd0, rv_m, "init");
        end
        for (int n = 0; n < 150; n++) begin
            int unsigned t   = $urandom_range(0, 3);
            logic [31:0] a   = $urandom;
            logic [31:0] d   = $urandom;
            logic [4:0]  ds  = 5'($urandom);
            logic        w   = 1'($urandom);
            logic        we  = (t >= 2);
            logic        re  = (t == 1) || (t == 3);
            int unsigned ix;
`ifdef MEM_BOUNDS_CHECK_EN
            if (we | re) a = 32'd1024 + 32'($urandom_range(0, 255));
`else
            if ((we | re) && $urandom_range(0, 1) == 1) a = 32'd1024 + 32'($urandom_range(0, 1023));
`endif
            ix = widx(a);
            if (re && !we) rv_m = mdl[ix];
            run_op(we, re, w, a, d, ds, rv_m, $sformatf("rnd%0d", n));
            if (we) mdl[ix] = d;
        end

        // LATENCY=1 back-to-back loads
        do_reset();
        use1 = 1'b1;
        run_op(1, 0, 0, 32'd1024, 32'h11, 5'd0, 32'h0, "l1 st0");
        run_op(1, 0, 0, 32'd1028, 32'h22, 5'd0, 32'h0, "l1 st1");
        run_op(0, 1, 1, 32'd1024, 0, 5'd4, 32'h11, "l1 ld0");
        run_op(0, 1, 1, 32'd1028, 0, 5'd8, 32'h22, "l1 ld1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
